// File: rtl/axi_ddr_responder.sv
// axi_ddr_responder: AXI4 slave backed by a block-RAM line store (128-bit lines).
// Optional read/B latency via `define AXI_DDR_RESP_LATENCY_EN (uses RD_LATENCY).
module axi_ddr_responder #(
    parameter int DEPTH_LOG2 = 14,
    parameter int RD_LATENCY = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [26:0]   S_AXI_AWADDR,
    input  logic [7:0]    S_AXI_AWLEN,
    input  logic          S_AXI_AWVALID,
    output logic          S_AXI_AWREADY,
    input  logic [127:0]  S_AXI_WDATA,
    input  logic [15:0]   S_AXI_WSTRB,
    input  logic          S_AXI_WLAST,
    input  logic          S_AXI_WVALID,
    output logic          S_AXI_WREADY,
    output logic [1:0]    S_AXI_BRESP,
    output logic          S_AXI_BVALID,
    input  logic          S_AXI_BREADY,
    input  logic [26:0]   S_AXI_ARADDR,
    input  logic [7:0]    S_AXI_ARLEN,
    input  logic          S_AXI_ARVALID,
    output logic          S_AXI_ARREADY,
    output logic [127:0]  S_AXI_RDATA,
    output logic [1:0]    S_AXI_RRESP,
    output logic          S_AXI_RLAST,
    output logic          S_AXI_RVALID,
    input  logic          S_AXI_RREADY
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    localparam ptr_t PTR_ONE = ptr_t'(1);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_FETCH, R_DATA} r_state_t;

    logic [127:0] mem [DEPTH];

    w_state_t    w_state;
    ptr_t        wptr;
    logic [7:0]  wlen;
    logic [7:0]  wcnt;
    logic        werr;
    logic        w_hs;
    logic        w_err_fin;

    r_state_t    r_state;
    ptr_t        rptr;
    logic [7:0]  rlen;
    logic [7:0]  rcnt;
    logic [7:0]  rcnt_nx;

`ifdef AXI_DDR_RESP_LATENCY_EN
    logic [15:0] wlat_cnt;
    logic [15:0] rlat_cnt;
`else
    logic        unused_lat;
    assign unused_lat = (RD_LATENCY != 0);
`endif

    // Only the line-index slice of each address selects storage.
    logic unused_addr;
    assign unused_addr = ^{S_AXI_AWADDR[3:0], S_AXI_AWADDR[26:4+DEPTH_LOG2],
                           S_AXI_ARADDR[3:0], S_AXI_ARADDR[26:4+DEPTH_LOG2]};

    assign w_hs      = S_AXI_WVALID & S_AXI_WREADY;
    assign w_err_fin = werr | ~S_AXI_WLAST;
    assign rcnt_nx   = rcnt + 8'd1;
    assign S_AXI_RRESP = 2'b00;

    // Byte-enabled line store write; a beat coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && w_hs) begin
            for (int i = 0; i < 16; i++) begin
                if (S_AXI_WSTRB[i]) mem[wptr][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
            end
        end
    end

    // Write channel FSM: AW accept, W beats into the store, B response.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state       <= W_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= 2'b00;
            wptr          <= '0;
            wlen          <= '0;
            wcnt          <= '0;
            werr          <= 1'b0;
`ifdef AXI_DDR_RESP_LATENCY_EN
            wlat_cnt      <= '0;
`endif
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    S_AXI_AWREADY <= 1'b1;
                    if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                        wptr          <= S_AXI_AWADDR[4 +: DEPTH_LOG2];
                        wlen          <= S_AXI_AWLEN;
                        wcnt          <= '0;
                        werr          <= 1'b0;
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_WREADY  <= 1'b1;
                        w_state       <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        wptr <= wptr + PTR_ONE;
                        wcnt <= wcnt + 8'd1;
                        if (wcnt == wlen) begin
                            S_AXI_WREADY <= 1'b0;
                            werr         <= w_err_fin;
`ifdef AXI_DDR_RESP_LATENCY_EN
                            wlat_cnt     <= 16'(RD_LATENCY - 1);
                            w_state      <= W_WAIT;
`else
                            S_AXI_BVALID <= 1'b1;
                            S_AXI_BRESP  <= {w_err_fin, 1'b0};
                            w_state      <= W_RESP;
`endif
                        end else if (S_AXI_WLAST) begin
                            werr <= 1'b1;
                        end
                    end
                end
`ifdef AXI_DDR_RESP_LATENCY_EN
                W_WAIT: begin
                    if (wlat_cnt == 16'd0) begin
                        S_AXI_BVALID <= 1'b1;
                        S_AXI_BRESP  <= {werr, 1'b0};
                        w_state      <= W_RESP;
                    end else begin
                        wlat_cnt <= wlat_cnt - 16'd1;
                    end
                end
`endif
                W_RESP: begin
                    if (S_AXI_BVALID && S_AXI_BREADY) begin
                        S_AXI_BVALID  <= 1'b0;
                        S_AXI_BRESP   <= 2'b00;
                        S_AXI_AWREADY <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read channel FSM: RDATA is the RAM output register, refilled on each R handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RLAST   <= 1'b0;
            S_AXI_RDATA   <= '0;
            rptr          <= '0;
            rlen          <= '0;
            rcnt          <= '0;
`ifdef AXI_DDR_RESP_LATENCY_EN
            rlat_cnt      <= '0;
`endif
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    S_AXI_ARREADY <= 1'b1;
                    if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                        rptr          <= S_AXI_ARADDR[4 +: DEPTH_LOG2];
                        rlen          <= S_AXI_ARLEN;
                        rcnt          <= '0;
                        S_AXI_ARREADY <= 1'b0;
`ifdef AXI_DDR_RESP_LATENCY_EN
                        rlat_cnt      <= 16'(RD_LATENCY - 1);
                        r_state       <= R_WAIT;
`else
                        r_state       <= R_FETCH;
`endif
                    end
                end
`ifdef AXI_DDR_RESP_LATENCY_EN
                R_WAIT: begin
                    if (rlat_cnt == 16'd0) r_state <= R_FETCH;
                    else rlat_cnt <= rlat_cnt - 16'd1;
                end
`endif
                R_FETCH: begin
                    S_AXI_RDATA  <= mem[rptr];
                    rptr         <= rptr + PTR_ONE;
                    S_AXI_RVALID <= 1'b1;
                    S_AXI_RLAST  <= (rlen == 8'd0);
                    r_state      <= R_DATA;
                end
                R_DATA: begin
                    if (S_AXI_RVALID && S_AXI_RREADY) begin
                        if (rcnt == rlen) begin
                            S_AXI_RVALID  <= 1'b0;
                            S_AXI_RLAST   <= 1'b0;
                            S_AXI_ARREADY <= 1'b1;
                            r_state       <= R_IDLE;
                        end else begin
                            S_AXI_RDATA <= mem[rptr];
                            rptr        <= rptr + PTR_ONE;
                            rcnt        <= rcnt_nx;
                            S_AXI_RLAST <= (rcnt_nx == rlen);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule
